// File: rtl/wm_detector.sv
// rtl/wm_detector.sv - keyed watermark symbol verifier (receive side)
//
// Purpose: regenerates the keyed 8-bit LFSR sequence, compares each received
// 2-bit watermark symbol with the locally expected symbol, counts matches over
// a frame of FRAME_LEN symbols and reports detected = (match_cnt >= THRESH).
//
// Optional feature macro: WM_DETECTOR_BITERR_EN
//   adds biterr_cnt (frame Hamming distance) and mismatch (registered flag).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, begins (or restarts) a frame
//   sym_valid  in   sym_in valid this cycle
//   sym_in     in   [1:0] extracted watermark symbol
//   sym_ready  out  symbol accepted this cycle when sym_valid is high
//   busy       out  frame in progress (RUN and the DONE cycle)
//   done       out  one-cycle pulse, verdict valid
//   detected   out  verdict, held until next start
//   match_cnt  out  [CNT_W-1:0] matches in current/last frame
//   sym_cnt    out  [CNT_W-1:0] symbols consumed in current/last frame
//   biterr_cnt out  [CNT_W:0] summed Hamming distance (optional)
//   mismatch   out  high the cycle after a mismatching accept (optional)
module wm_detector #(
  parameter logic [7:0] KEY       = 8'b01101010,
  parameter int         FRAME_LEN = 1024,
  parameter int         THRESH    = 900,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sym_valid,
  input  logic [1:0]       sym_in,
  output logic             sym_ready,
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] sym_cnt
`ifdef WM_DETECTOR_BITERR_EN
  ,
  output logic [CNT_W:0]   biterr_cnt,
  output logic             mismatch
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             detected_q, detected_d;
  logic [CNT_W-1:0] sym_cnt_inc, match_cnt_inc;
  logic             fb, exp_hi;
  logic [1:0]       exp_sym;
  logic             take, restart, hit;

  // Feedback bit kept separate so the step vector never reads itself.
  assign fb        = lfsr_q[7] ^ (lfsr_q[6:0] == 7'd0);
  assign lfsr_step = {lfsr_q[6], lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ fb,
                      lfsr_q[2] ^ fb, lfsr_q[1] ^ fb, lfsr_q[0], fb};

  // Expected symbol depends only on the registered LFSR state.
  assign exp_hi  = lfsr_q[1] ^ lfsr_q[0];
  assign exp_sym = {exp_hi, exp_hi ? 1'b0 : lfsr_q[0]};
  assign hit     = (sym_in == exp_sym);

  // start outranks a symbol in RUN; start during DONE is ignored.
  assign restart = start & (state_q != S_DONE);
  assign take    = (state_q == S_RUN) & sym_valid & ~start;

  assign sym_cnt_inc   = (sym_cnt_q == CNT_MAX) ? sym_cnt_q : sym_cnt_q + CNT_W'(1);
  assign match_cnt_inc = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    match_cnt_d = match_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    detected_d  = detected_q;
    sym_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (restart) state_d = S_RUN;
      end
      S_RUN: begin
        sym_ready = 1'b1;
        busy      = 1'b1;
        if (take) begin
          lfsr_d    = lfsr_step;
          sym_cnt_d = sym_cnt_inc;
          if (hit) match_cnt_d = match_cnt_inc;
          // Verdict is computed on the final accept so it is already valid
          // in the DONE cycle alongside the done pulse.
          if (sym_cnt_inc == FRAME_C) begin
            state_d    = S_DONE;
            detected_d = (match_cnt_d >= THRESH_C);
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (restart) begin
      lfsr_d      = KEY;
      match_cnt_d = '0;
      sym_cnt_d   = '0;
      detected_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= KEY;
      match_cnt_q <= '0;
      sym_cnt_q   <= '0;
      detected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      match_cnt_q <= match_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      detected_q  <= detected_d;
    end
  end

  assign detected  = detected_q;
  assign match_cnt = match_cnt_q;
  assign sym_cnt   = sym_cnt_q;

`ifdef WM_DETECTOR_BITERR_EN
  logic [CNT_W:0] biterr_q, biterr_d, ham;
  logic           mismatch_q, mismatch_d;
  logic [1:0]     diff;

  always_comb begin
    diff       = sym_in ^ exp_sym;
    ham        = (CNT_W+1)'(diff[1]) + (CNT_W+1)'(diff[0]);
    biterr_d   = biterr_q;
    mismatch_d = 1'b0;
    if (restart) begin
      biterr_d = '0;
    end else if (take) begin
      biterr_d   = biterr_q + ham;
      mismatch_d = |diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      biterr_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      biterr_q   <= biterr_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign biterr_cnt = biterr_q;
  assign mismatch   = mismatch_q;
`endif

endmodule

// File: doc/wm_detector.md
Name: wm_detector

Overview:
- Watermark extraction/verification block, the receive end of the keyed watermark path.
- Takes the 2-bit watermark symbols recovered from pixel LSBs, one per handshake.
- Regenerates the same keyed 8-bit sequence locally and compares each received symbol against the expected symbol.
- Counts matches over a frame and reports a detected/not-detected verdict against a threshold.

Parameters:
- KEY, 8'b01101010, LFSR seed; must equal the embedding key.
- FRAME_LEN, 1024, symbols per verification frame (>=1, < 2^CNT_W).
- THRESH, 900, minimum match count for detected=1 (<= FRAME_LEN).
- CNT_W, 16, width of the symbol and match counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new frame
- sym_valid  in  1  sym_in is valid this cycle
- sym_in  in  2  extracted watermark symbol
- sym_ready  out  1  block accepts a symbol this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the verdict is valid
- detected  out  1  verdict: match_cnt >= THRESH; held until next start
- match_cnt  out  CNT_W  matches in the current/last frame
- sym_cnt  out  CNT_W  symbols consumed in the current/last frame

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, lfsr=KEY, sym_ready=0, busy=0, done=0, detected=0, match_cnt=0, sym_cnt=0. Reset mid-frame aborts the frame with no done pulse.
- LFSR next state, q = current 8-bit register:
  - d0 = q[7] ^ (q[6:0]==0)
  - d1 = q0; d2 = q1^d0; d3 = q2^d0; d4 = q3^d0
  - d5 = q4; d6 = q5; d7 = q6
- Expected symbol from the current q: exp[1] = q1^q0; exp[0] = exp[1] ? 0 : q0. This is combinational from the registered state only, with no loop.
- Accept = sym_valid & sym_ready. On accept:
  - lfsr advances one step.
  - sym_cnt += 1.
  - match_cnt += 1 if sym_in == exp.
  - The comparison uses the pre-advance state.
- FSM:
  - IDLE: sym_ready=0, busy=0. On start: lfsr<=KEY, match_cnt<=0, sym_cnt<=0, detected<=0, go to RUN.
  - RUN: sym_ready=1, busy=1. When accepting the symbol that makes sym_cnt==FRAME_LEN, go to DONE. That last symbol's match is included.
  - DONE: exactly one cycle. sym_ready=0, done=1, detected<=(final match_cnt >= THRESH), then go to IDLE.
- Latency: verdict appears 1 cycle after the last accepted symbol (done high in the cycle after the accept edge). detected is valid in the same cycle as done.
- start while in RUN restarts the frame: counters cleared, lfsr<=KEY. A symbol presented in that same cycle is not consumed, because start has priority.
- start during DONE is ignored.
- sym_valid while not in RUN is ignored; no state change.
- Counters saturate: never wrap, since FRAME_LEN < 2^CNT_W.
- Outputs match_cnt, sym_cnt and detected hold their last values through IDLE until the next start.

Optional Feature:
- Macro: WM_DETECTOR_BITERR_EN
- Defined:
  - Adds output biterr_cnt [CNT_W+1-1:0], the Hamming distance between sym_in and exp summed over the frame (0, 1 or 2 per symbol).
  - biterr_cnt is cleared on rst and start, and updated on accept.
  - Adds output mismatch (1 bit), registered, high for one cycle after any accepted symbol with sym_in != exp.
- Undefined: neither port exists and no extra logic is present; all other behaviour is identical.

Test Plan:
- Reset then start, feeding the ideal sequence with FRAME_LEN=8, THRESH=6 -> first expected symbols are 2'b10, 2'b00, 2'b10 (lfsr 0x6A->0xD4->0xB5). done pulses 1 cycle after the 8th accept with match_cnt=8, sym_cnt=8, detected=1.
- Same frame with all symbols inverted (sym_in = ~exp) -> match_cnt=0, detected=0. With BITERR_EN: biterr_cnt=16.
- Ideal sequence with exactly 2 corrupted symbols, FRAME_LEN=8, THRESH=6 -> match_cnt=6, detected=1. With 3 corrupted: match_cnt=5, detected=0 (threshold boundary).
- sym_valid toggled 1/0 each cycle -> only accepted cycles advance the lfsr. The verdict is identical to the gap-free run.
- start re-asserted after 5 accepts -> counters return to 0, lfsr=0x6A, no done for the aborted frame. The next 8 ideal symbols give match_cnt=8.
- rst asserted mid-RUN after 3 accepts -> next cycle is IDLE with sym_ready=0 and all outputs 0. No done pulse ever occurs for that frame.
